// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall scheduler for the 5-stage RV32 pipeline. Produces the
//   stall/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB buffers,
//   the EX-stage operand forwarding selects, and sequences multi-cycle EX
//   operations and data-memory wait states. Also keeps saturating
//   stall/flush performance counters and a sticky multi-cycle timeout flag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   Rs1D/Rs2D                source register addresses in ID
//   Rs1E/Rs2E/RdE            source/destination register addresses in EX
//   RdM/RdW, RegWriteM/W     destination and write enable in MEM / WB
//   ResultSrcE               EX result source (2'b01 = load)
//   PCSrcE                   taken branch/jump resolved in EX
//   MultiCycE, MultiCycDone  multi-cycle EX op present / result valid pulse
//   MemReqM, MemReadyM       MEM data access present / completes this cycle
//   StallF/D/E/M             hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/M/W             clear IF/ID, ID/EX, bubble EX/MEM, MEM/WB
//   ForwardAE/BE             operand select: 00 reg, 01 WB, 10 MEM
//   MultiStart               1-cycle start pulse to the multi-cycle unit
//   McError                  sticky multi-cycle timeout flag
//   StallCnt/FlushCnt        saturating counts of StallF / FlushE cycles
//   fsm_state                debug view of the FSM (0 IDLE, 1 MC_BUSY, 2 MEM_WAIT)
//
// Handshake: MultiStart is a single-cycle request; the unit answers with a
// single-cycle MultiCycDone. Memory accesses complete in the cycle where
// MemReqM and MemReadyM are both high.

module pipeline_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MultiCycE,
  input  logic             MultiCycDone,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MultiStart,
  output logic             McError,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MC_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Wide enough to hold MC_TIMEOUT-1, the terminal count.
  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] mc_cnt;
  logic          lw_stall;
  logic          mc_expire;
  logic          do_idle;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

  assign mc_expire = (state == MC_BUSY) && !MultiCycDone &&
                     (mc_cnt == TW'(MC_TIMEOUT - 1));

  // A completed memory wait behaves exactly like IDLE for that cycle, so a
  // multi-cycle op queued behind the access can start immediately.
  assign do_idle   = (state == IDLE) || ((state == MEM_WAIT) && MemReadyM);

  assign fsm_state = state;

  always_comb begin
    state_nxt  = state;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    FlushW     = 1'b0;
    MultiStart = 1'b0;
    if (do_idle) begin
      if (MemReqM && !MemReadyM) begin
        {StallF, StallD, StallE, StallM} = 4'b1111;
        FlushW    = 1'b1;
        state_nxt = MEM_WAIT;
      end else if (MultiCycE) begin
        MultiStart = 1'b1;
        {StallF, StallD, StallE} = 3'b111;
        FlushM    = 1'b1;
        state_nxt = MC_BUSY;
      end else begin
        StallF    = lw_stall;
        StallD    = lw_stall;
        FlushE    = lw_stall || PCSrcE;
        FlushD    = PCSrcE;
        state_nxt = IDLE;
      end
    end else if (state == MC_BUSY) begin
      if (MultiCycDone || mc_expire) begin
        // Result (or abort) lets EX/MEM capture; normal hazards apply again.
        StallF    = lw_stall;
        StallD    = lw_stall;
        FlushE    = lw_stall || PCSrcE;
        FlushD    = PCSrcE;
        state_nxt = IDLE;
      end else begin
        {StallF, StallD, StallE} = 3'b111;
        FlushM = 1'b1;
      end
    end else begin
      // MEM_WAIT, memory not ready yet.
      {StallF, StallD, StallE, StallM} = 4'b1111;
      FlushW = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mc_cnt   <= '0;
      McError  <= 1'b0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == MC_BUSY && state_nxt == MC_BUSY) mc_cnt <= mc_cnt + TW'(1);
      else                                          mc_cnt <= '0;
      if (mc_expire) McError <= 1'b1;
      if (StallF && StallCnt != {CNT_W{1'b1}}) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushE && FlushCnt != {CNT_W{1'b1}}) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int MC_TIMEOUT = 8;
  localparam int CNT_W      = 6;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic RegWriteM = 0, RegWriteW = 0, PCSrcE = 0, MultiCycE = 0, MultiCycDone = 0;
  logic MemReqM = 0, MemReadyM = 0;
  logic [1:0] ResultSrcE = '0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MultiStart, McError;
  logic [1:0] ForwardAE, ForwardBE, fsm_state;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  pipeline_hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MultiCycE(MultiCycE), .MultiCycDone(MultiCycDone), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MultiStart(MultiStart), .McError(McError),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .fsm_state(fsm_state)
  );

  logic [12:0] obs;
  logic [14:0] regs;
  assign obs  = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                 ForwardAE, ForwardBE, MultiStart};
  assign regs = {McError, StallCnt, FlushCnt, fsm_state};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Tracks "multi-cycle op outstanding" and "memory access outstanding" as
  // flags plus an elapsed-cycle count, and derives each cycle's controls.
  bit m_mc, m_mem, m_err, n_mc, n_mem, n_err;
  int m_elapsed, n_elapsed, m_scnt, m_fcnt;
  bit e_sf, e_fe;
  logic [12:0] exp_outs;
  logic [14:0] exp_regs;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_mc = 0; m_mem = 0; m_err = 0; m_elapsed = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_eval();
    bit sf, sd, se, sm, fd, fe, fm, fw, ms, lw, normal;
    logic [1:0] st;
    lw = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    {sf, sd, se, sm, fd, fe, fm, fw, ms, normal} = '0;
    n_mc = m_mc; n_mem = m_mem; n_err = m_err; n_elapsed = m_elapsed;
    if (m_mc) begin
      if (!MultiCycDone && m_elapsed < MC_TIMEOUT - 1) begin
        sf = 1; sd = 1; se = 1; fm = 1; n_elapsed = m_elapsed + 1;
      end else begin
        normal = 1; n_mc = 0; n_elapsed = 0;
        if (!MultiCycDone) n_err = 1;
      end
    end else if (m_mem && !MemReadyM) begin
      sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
    end else begin
      n_mem = 0;
      if (MemReqM && !MemReadyM) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1; n_mem = 1;
      end else if (MultiCycE) begin
        ms = 1; sf = 1; sd = 1; se = 1; fm = 1; n_mc = 1; n_elapsed = 0;
      end else normal = 1;
    end
    if (normal) begin
      sf = lw; sd = lw; fe = lw || PCSrcE; fd = PCSrcE;
    end
    e_sf = sf; e_fe = fe;
    exp_outs = {sf, sd, se, sm, fd, fe, fm, fw, ref_fwd(Rs1E), ref_fwd(Rs2E), ms};
    st = m_mc ? 2'd1 : (m_mem ? 2'd2 : 2'd0);
    exp_regs = {m_err, CNT_W'(m_scnt), CNT_W'(m_fcnt), st};
  endtask

  task automatic model_commit();
    m_mc = n_mc; m_mem = n_mem; m_err = n_err; m_elapsed = n_elapsed;
    if (e_sf && m_scnt < CNT_MAX) m_scnt++;
    if (e_fe && m_fcnt < CNT_MAX) m_fcnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MultiCycE, MultiCycDone, MemReqM, MemReadyM} = '0;
    ResultSrcE = 2'b00;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1 model_eval();
    checks++;
    if (obs !== exp_outs) begin errors++; $display("FAIL reset_outs: got %b want %b", obs, exp_outs); end
    checks++;
    if (regs !== 15'd0) begin errors++; $display("FAIL reset_regs: got %h want 0", regs); end
    advance();
  endtask

  task automatic test_forwarding();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      case (c)
        0: begin RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1; end
        1: begin RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 6; RegWriteW = 1; end
        default: begin RdM = 0; RdW = 0; Rs1E = 0; RegWriteM = 1; RegWriteW = 1; end
      endcase
      #1 model_eval();
      checks++;
      if (obs !== exp_outs) begin errors++; $display("FAIL fwd c%0d: got %b want %b", c, obs, exp_outs); end
      checks++;
      if (regs !== exp_regs) begin errors++; $display("FAIL fwd_regs c%0d: got %h want %h", c, regs, exp_regs); end
      advance();
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      if (c == 0) begin ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 3; end
      #1 model_eval();
      checks++;
      if (obs !== exp_outs) begin errors++; $display("FAIL load_use c%0d: got %b want %b", c, obs, exp_outs); end
      checks++;
      if (regs !== exp_regs) begin errors++; $display("FAIL load_use_regs c%0d: got %h want %h", c, regs, exp_regs); end
      advance();
    end
  endtask

  task automatic test_branch();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      if (c == 0) PCSrcE = 1;
      if (c == 1) begin PCSrcE = 1; ResultSrcE = 2'b01; RdE = 9; Rs1D = 9; end
      #1 model_eval();
      checks++;
      if (obs !== exp_outs) begin errors++; $display("FAIL branch c%0d: got %b want %b", c, obs, exp_outs); end
      checks++;
      if (regs !== exp_regs) begin errors++; $display("FAIL branch_regs c%0d: got %h want %h", c, regs, exp_regs); end
      advance();
    end
  endtask

  task automatic test_multicycle();
    int starts = 0;
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      MultiCycE    = (c <= 4);
      MultiCycDone = (c == 4);
      PCSrcE       = (c == 2);  // must be ignored while EX is held
      #1 model_eval();
      if (MultiStart === 1'b1) starts++;
      checks++;
      if (obs !== exp_outs) begin errors++; $display("FAIL multicycle c%0d: got %b want %b", c, obs, exp_outs); end
      checks++;
      if (regs !== exp_regs) begin errors++; $display("FAIL multicycle_regs c%0d: got %h want %h", c, regs, exp_regs); end
      advance();
    end
    checks++;
    if (starts != 1) begin errors++; $display("FAIL multicycle_starts: got %0d want 1", starts); end
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 9; c++) begin
      clear_inputs();
      MemReqM      = (c <= 3);
      MemReadyM    = (c == 3);
      MultiCycE    = (c <= 6);
      MultiCycDone = (c == 6);
      #1 model_eval();
      checks++;
      if (obs !== exp_outs) begin errors++; $display("FAIL mem_wait c%0d: got %b want %b", c, obs, exp_outs); end
      checks++;
      if (regs !== exp_regs) begin errors++; $display("FAIL mem_wait_regs c%0d: got %h want %h", c, regs, exp_regs); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      if (c <= 1) begin ResultSrcE = 2'b01; RdE = 4; Rs1D = 4; end
      if (c == 2) MultiCycE = 1;
      if (c == 3) begin MultiCycE = 1; MultiCycDone = 1; PCSrcE = 1; MemReqM = 1; end
      if (c == 4) begin MemReqM = 1; end
      if (c == 5) begin MemReqM = 1; MemReadyM = 1; PCSrcE = 1; end
      #1 model_eval();
      checks++;
      if (obs !== exp_outs) begin errors++; $display("FAIL back_to_back c%0d: got %b want %b", c, obs, exp_outs); end
      checks++;
      if (regs !== exp_regs) begin errors++; $display("FAIL back_to_back_regs c%0d: got %h want %h", c, regs, exp_regs); end
      advance();
    end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      MultiCycE = (c == 0);
      #1 model_eval();
      if (McError === 1'b0 && StallF === 1'b1) stalls++;
      checks++;
      if (obs !== exp_outs) begin errors++; $display("FAIL timeout c%0d: got %b want %b", c, obs, exp_outs); end
      checks++;
      if (regs !== exp_regs) begin errors++; $display("FAIL timeout_regs c%0d: got %h want %h", c, regs, exp_regs); end
      advance();
    end
    checks++;
    if (stalls != MC_TIMEOUT) begin errors++; $display("FAIL timeout_stalls: got %0d want %0d", stalls, MC_TIMEOUT); end
    checks++;
    if (McError !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", McError); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM    = ($urandom_range(0, 1) == 1);
      RegWriteW    = ($urandom_range(0, 1) == 1);
      ResultSrcE   = 2'($urandom_range(0, 3));
      PCSrcE       = ($urandom_range(0, 3) == 0);
      MultiCycE    = ($urandom_range(0, 7) == 0);
      MultiCycDone = ($urandom_range(0, 4) == 0);
      MemReqM      = ($urandom_range(0, 3) == 0);
      MemReadyM    = ($urandom_range(0, 1) == 1);
      #1 model_eval();
      checks++;
      if (obs !== exp_outs) begin errors++; $display("FAIL random c%0d: got %b want %b", c, obs, exp_outs); end
      checks++;
      if (regs !== exp_regs) begin errors++; $display("FAIL random_regs c%0d: got %h want %h", c, regs, exp_regs); end
      advance();
    end
  endtask

  task automatic test_reset_clear();
    // Enter MC_BUSY, then reset in the middle of the operation.
    clear_inputs();
    MultiCycE = 1;
    #1 model_eval();
    advance();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1 model_eval();
    checks++;
    if (regs !== 15'd0) begin errors++; $display("FAIL reset_clear_regs: got %h want 0", regs); end
    checks++;
    if (obs !== exp_outs) begin errors++; $display("FAIL reset_clear_outs: got %b want %b", obs, exp_outs); end
    advance();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multicycle();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and stall scheduler for the 5-stage RV32 pipeline. It drives stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB buffers and the EX-stage operand forwarding selects. It sequences multi-cycle EX operations (mul/div) and data-memory wait states through an FSM. It also keeps saturating stall and flush performance counters.

Parameters:
MC_TIMEOUT, 64, max cycles in MC_BUSY before abort (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  reset
Rs1D  in  5  rs1 address in ID
Rs2D  in  5  rs2 address in ID
Rs1E  in  5  rs1 address in EX
Rs2E  in  5  rs2 address in EX
RdE  in  5  rd in EX
RdM  in  5  rd in MEM
RdW  in  5  rd in WB
RegWriteM  in  1  MEM instr writes rd
RegWriteW  in  1  WB instr writes rd
ResultSrcE  in  2  EX result source; 2'b01 = load
PCSrcE  in  1  taken branch/jump resolved in EX
MultiCycE  in  1  EX instr is multi-cycle
MultiCycDone  in  1  multi-cycle unit result valid, 1-cycle pulse
MemReqM  in  1  MEM instr accesses data memory
MemReadyM  in  1  data memory completes this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushM  out  1  bubble into EX/MEM
FlushW  out  1  bubble into MEM/WB
ForwardAE  out  2  operand A select: 00 reg, 01 WB, 10 MEM
ForwardBE  out  2  operand B select, same encoding
MultiStart  out  1  1-cycle start pulse to multi-cycle unit
McError  out  1  sticky timeout flag
StallCnt  out  CNT_W  cycles with StallF=1
FlushCnt  out  CNT_W  cycles with FlushE=1

Behaviour:
- rst (synchronous, active-high; clock clk): state=IDLE, timeout counter=0, McError=0, StallCnt=0, FlushCnt=0. Combinational outputs follow the equations below with state=IDLE.
- Forwarding (combinational, all states):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00.
  - MEM has priority over WB. ForwardBE uses the same rules with Rs2E.
- Load-use: lwStall = ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: IDLE, MC_BUSY, MEM_WAIT.
- IDLE:
  - If MemReqM && !MemReadyM: go to MEM_WAIT. Same cycle: StallF=StallD=StallE=StallM=1, FlushW=1, MultiStart=0. Memory wait has priority over multi-cycle start.
  - Else if MultiCycE: MultiStart=1, go to MC_BUSY. Same cycle: StallF=StallD=StallE=1, FlushM=1.
  - Else normal operation:
    - StallF=StallD=lwStall.
    - FlushE=lwStall||PCSrcE.
    - FlushD=PCSrcE.
    - All other stall/flush outputs are 0.
- MC_BUSY:
  - While MultiCycDone=0: StallF=StallD=StallE=1, FlushM=1, timeout counter increments.
  - On MultiCycDone=1: all stalls are 0 that cycle (EX/MEM captures the result), PCSrcE/lwStall equations apply, next state=IDLE, counter cleared.
  - When the counter reaches MC_TIMEOUT-1 without done: set McError, release stalls as on done, return to IDLE.
  - MultiStart=0.
- MEM_WAIT:
  - StallF=StallD=StallE=StallM=1 and FlushW=1 until MemReadyM=1.
  - On MemReadyM=1: stalls released that same cycle, IDLE equations apply, next state=IDLE.
- Any cycle with StallE=1: PCSrcE and lwStall are ignored (FlushD=FlushE=0), since the EX instruction has not advanced.
- PCSrcE && lwStall together: FlushE=1, FlushD=1, StallF=StallD=1.
- Counters: increment on StallF and FlushE respectively, saturate at all-ones.
- McError clears only on rst.
- rst mid-MC_BUSY or mid-MEM_WAIT: immediate return to IDLE, no MultiStart pulse.

Test Plan:
- Forwarding: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set Rs1E=0 with RdM=RdW=0 -> 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle; StallCnt+1, FlushCnt+1.
- Branch flush: PCSrcE=1 in IDLE -> FlushD=FlushE=1, no stalls. Same with lwStall=1 -> FlushE=1, StallF=StallD=1.
- Multi-cycle: MultiCycE=1, MultiCycDone on cycle 4 -> MultiStart at cycle 0 only; StallE=1 and FlushM=1 for cycles 0-3; all 0 at cycle 4; state IDLE at cycle 5.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles while MultiCycE=1 -> StallM=FlushW=1 for 3 cycles, no MultiStart; MultiStart on cycle 3 after ready.
- Timeout/reset: MC_TIMEOUT=8, no done -> McError rises after 8 stall cycles, stalls released. A later rst clears McError and both counters.
